hazard_scoreboard: RTL and testbench

Parametrised, scoreboard-based hazard unit for the decode stage.
- It generalises fixed scalar and vector FIFO compares into per-register countdown tracking across NUM_RF register files.
- Issue latency is variable per instruction, so it serves the 2-deep scalar pipe and the deep vector pipe uniformly.
- Per cycle it produces RAW, WAW and writeback-port (structural) stalls plus per-source forward selects.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/wb_reservation_ring.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 219 +++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types, default sizing and helpers for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned NUM_RF_DEF   = 2;
  localparam int unsigned NUM_SRC_DEF  = 4;
  localparam int unsigned MAX_LAT_DEF  = 12;
  localparam int unsigned FWD_DIST_DEF = 2;

  localparam int unsigned REG_IDX_W = $clog2(NUM_REGS_DEF);
  localparam int unsigned RF_SEL_W  = (NUM_RF_DEF > 1) ? $clog2(NUM_RF_DEF) : 1;
  localparam int unsigned LAT_T_W   = $clog2(MAX_LAT_DEF + 1);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [RF_SEL_W-1:0]  rf_sel_t;
  typedef logic [LAT_T_W-1:0]   lat_t;

  localparam rf_sel_t RF_SCALAR = rf_sel_t'(0);
  localparam rf_sel_t RF_VECTOR = rf_sel_t'(1);

  // Out-of-range latencies are squeezed into 1..max_lat so tracking stays consistent.
  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
    if (lat == 0) return 1;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/wb_reservation_ring.sv
// Per-register-file writeback reservation ring: bit k set means a write lands k edges from now.
module wb_reservation_ring #(
  parameter int unsigned MAX_LAT = 12,
  parameter int unsigned LAT_W   = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic             rsv_en_i,
  input  logic [LAT_W-1:0] rsv_lat_i,
  input  logic [LAT_W-1:0] query_lat_i,
  output logic             query_hit_o,
  output logic             wb_o,
  output logic [MAX_LAT:1] resv_o
);

  logic [MAX_LAT:1] resv_q, resv_d;

  // Shift toward slot 1 on every advancing edge, then drop in the new reservation.
  always_comb begin
    resv_d = resv_q;
    if (adv_i) resv_d = resv_q >> 1;
    if (rsv_en_i) begin
      for (int k = 1; k <= int'(MAX_LAT); k++) begin
        if (rsv_lat_i == LAT_W'(k)) resv_d[k] = 1'b1;
      end
    end
  end

  // Query a slot; indices outside 1..MAX_LAT never collide.
  always_comb begin
    query_hit_o = 1'b0;
    for (int k = 1; k <= int'(MAX_LAT); k++) begin
      if (query_lat_i == LAT_W'(k)) query_hit_o = resv_q[k];
    end
  end

  // Ring state, cleared by reset or flush.
  always_ff @(posedge clk_i) begin
    if (clr_i) resv_q <= '0;
    else       resv_q <= resv_d;
  end

  assign wb_o   = resv_q[1];
  assign resv_o = resv_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register countdowns give RAW/WAW stalls and forward
// selects; per-file reservation rings catch writeback-port collisions.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter  int unsigned NUM_RF   = NUM_RF_DEF,
  parameter  int unsigned NUM_SRC  = NUM_SRC_DEF,
  parameter  int unsigned MAX_LAT  = MAX_LAT_DEF,
  parameter  int unsigned FWD_DIST = FWD_DIST_DEF,
  localparam int unsigned RF_W     = (NUM_RF > 1) ? $clog2(NUM_RF) : 1,
  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned LAT_W    = $clog2(MAX_LAT + 1),
  localparam int unsigned CNT_W    = $clog2(NUM_RF * NUM_REGS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     issue_valid_i,
  input  logic                     issue_wr_en_i,
  input  logic [RF_W-1:0]          issue_rf_i,
  input  logic [IDX_W-1:0]         issue_dst_i,
  input  logic [LAT_W-1:0]         issue_lat_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  input  logic [NUM_SRC*RF_W-1:0]  src_rf_i,
  input  logic [NUM_SRC*IDX_W-1:0] src_idx_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic                     stall_raw_o,
  output logic                     stall_waw_o,
  output logic                     stall_struct_o,
  output logic [NUM_SRC*LAT_W-1:0] fwd_sel_o,
  output logic [NUM_RF-1:0]        wb_expect_o,
  output logic [CNT_W-1:0]         inflight_o,
  output logic                     lat_err_o
);

  localparam logic [LAT_W-1:0] FWD_LIM = LAT_W'(FWD_DIST);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

  logic             busy_q [NUM_RF][NUM_REGS];
  logic             busy_d [NUM_RF][NUM_REGS];
  logic [LAT_W-1:0] cnt_q  [NUM_RF][NUM_REGS];
  logic [LAT_W-1:0] cnt_d  [NUM_RF][NUM_REGS];
  logic             lat_err_q, lat_err_d;

  logic             clr, advance, accept;
  logic [LAT_W-1:0] eff_lat, query_lat;
  logic             lat_bad;
  logic             dst_busy;
  logic [LAT_W-1:0] dst_cnt;
  logic             src_busy [NUM_SRC];
  logic [LAT_W-1:0] src_cnt  [NUM_SRC];
  logic [NUM_SRC-1:0] raw_vec;
  logic             raw_hit, waw_hit, struct_hit;
  logic [NUM_RF-1:0] ring_hit, rsv_en;
  logic             ring_hit_sel;
  logic [MAX_LAT:1] resv_vec [NUM_RF];

  assign clr       = rst_i | flush_i;
  assign advance   = ~hold_i;
  assign lat_bad   = (issue_lat_i == '0) || (32'(issue_lat_i) > MAX_LAT);
  assign eff_lat   = LAT_W'(clamp_lat(32'(issue_lat_i), MAX_LAT));
  assign query_lat = eff_lat + LAT_W'(1);

  // Scoreboard entry of the destination being issued.
  always_comb begin
    dst_busy = 1'b0;
    dst_cnt  = '0;
    for (int f = 0; f < int'(NUM_RF); f++) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        if (issue_rf_i == RF_W'(f) && issue_dst_i == IDX_W'(r)) begin
          dst_busy = busy_q[f][r];
          dst_cnt  = cnt_q[f][r];
        end
      end
    end
  end

  // Scoreboard entry of every source operand.
  always_comb begin
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      src_busy[s] = 1'b0;
      src_cnt[s]  = '0;
      for (int f = 0; f < int'(NUM_RF); f++) begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
          if (src_rf_i[s*RF_W +: RF_W] == RF_W'(f) && src_idx_i[s*IDX_W +: IDX_W] == IDX_W'(r)) begin
            src_busy[s] = busy_q[f][r];
            src_cnt[s]  = cnt_q[f][r];
          end
        end
      end
    end
  end

  // A producer close enough to writeback is forwarded; anything further out stalls.
  always_comb begin
    fwd_sel_o = '0;
    raw_vec   = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      if (src_valid_i[s] && src_busy[s]) begin
        if (src_cnt[s] > FWD_LIM) raw_vec[s] = 1'b1;
        else                      fwd_sel_o[s*LAT_W +: LAT_W] = src_cnt[s];
      end
    end
  end

  // Pick the collision answer from the destination file's ring.
  always_comb begin
    ring_hit_sel = 1'b0;
    for (int f = 0; f < int'(NUM_RF); f++) begin
      if (issue_rf_i == RF_W'(f)) ring_hit_sel = ring_hit[f];
    end
  end

  assign raw_hit    = |raw_vec;
  assign waw_hit    = issue_wr_en_i & dst_busy & (dst_cnt > eff_lat);
  assign struct_hit = issue_wr_en_i & (eff_lat < LAT_MAX) & ring_hit_sel;

  assign stall_raw_o    = issue_valid_i & raw_hit;
  assign stall_waw_o    = issue_valid_i & waw_hit;
  assign stall_struct_o = issue_valid_i & struct_hit;
  assign stall_o        = stall_raw_o | stall_waw_o | stall_struct_o;
  assign accept         = issue_valid_i & ~stall_o & ~hold_i;

  for (genvar f = 0; f < int'(NUM_RF); f++) begin : g_ring
    assign rsv_en[f] = accept & issue_wr_en_i & (issue_rf_i == RF_W'(f));

    wb_reservation_ring #(
      .MAX_LAT (MAX_LAT),
      .LAT_W   (LAT_W)
    ) u_ring (
      .clk_i       (clk_i),
      .clr_i       (clr),
      .adv_i       (advance),
      .rsv_en_i    (rsv_en[f]),
      .rsv_lat_i   (eff_lat),
      .query_lat_i (query_lat),
      .query_hit_o (ring_hit[f]),
      .wb_o        (wb_expect_o[f]),
      .resv_o      (resv_vec[f])
    );
  end

  // Countdown every busy entry; a fresh issue overrides its own entry's retire.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    lat_err_d = lat_err_q;
    if (advance) begin
      for (int f = 0; f < int'(NUM_RF); f++) begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
          if (busy_q[f][r]) begin
            if (cnt_q[f][r] == LAT_W'(1)) begin
              busy_d[f][r] = 1'b0;
              cnt_d[f][r]  = '0;
            end else begin
              cnt_d[f][r] = cnt_q[f][r] - LAT_W'(1);
            end
          end
        end
      end
    end
    if (accept) begin
      lat_err_d = lat_err_q | lat_bad;
      if (issue_wr_en_i) begin
        for (int f = 0; f < int'(NUM_RF); f++) begin
          for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (issue_rf_i == RF_W'(f) && issue_dst_i == IDX_W'(r)) begin
              busy_d[f][r] = 1'b1;
              cnt_d[f][r]  = eff_lat;
            end
          end
        end
      end
    end
  end

  // Scoreboard registers; flush clears exactly like reset.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      for (int f = 0; f < int'(NUM_RF); f++) begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
          busy_q[f][r] <= 1'b0;
          cnt_q[f][r]  <= '0;
        end
      end
      lat_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      lat_err_q <= lat_err_d;
    end
  end

  // Count busy registers across all files.
  always_comb begin
    inflight_o = '0;
    for (int f = 0; f < int'(NUM_RF); f++) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        inflight_o = inflight_o + CNT_W'(busy_q[f][r]);
      end
    end
  end

  assign lat_err_o = lat_err_q;

  // Every live countdown owns its ring slot; extra slots may linger after a re-issue.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int f = 0; f < int'(NUM_RF); f++) begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
          if (busy_q[f][r]) assert (resv_vec[f][cnt_q[f][r]]);
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues expectations, a negedge monitor checks them.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wr_en;
  logic [0:0]  issue_rf;
  logic [4:0]  issue_dst;
  logic [3:0]  issue_lat;
  logic [3:0]  src_valid;
  logic [3:0]  src_rf;
  logic [19:0] src_idx;
  logic        hold, flush;
  logic        stall, stall_raw, stall_waw, stall_struct;
  logic [15:0] fwd_sel;
  logic [1:0]  wb_expect;
  logic [6:0]  inflight;
  logic        lat_err;

  hazard_scoreboard dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_valid_i  (issue_valid),
    .issue_wr_en_i  (issue_wr_en),
    .issue_rf_i     (issue_rf),
    .issue_dst_i    (issue_dst),
    .issue_lat_i    (issue_lat),
    .src_valid_i    (src_valid),
    .src_rf_i       (src_rf),
    .src_idx_i      (src_idx),
    .hold_i         (hold),
    .flush_i        (flush),
    .stall_o        (stall),
    .stall_raw_o    (stall_raw),
    .stall_waw_o    (stall_waw),
    .stall_struct_o (stall_struct),
    .fwd_sel_o      (fwd_sel),
    .wb_expect_o    (wb_expect),
    .inflight_o     (inflight),
    .lat_err_o      (lat_err)
  );

  always #5 clk = ~clk;

  typedef enum {F_STALL, F_RAW, F_WAW, F_STRUCT, F_FWD0, F_WB, F_INFL, F_LATERR} fld_e;
  typedef struct {
    int    cyc;
    fld_e  fld;
    int    val;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual_of(input fld_e f);
    case (f)
      F_STALL:  return int'(stall);
      F_RAW:    return int'(stall_raw);
      F_WAW:    return int'(stall_waw);
      F_STRUCT: return int'(stall_struct);
      F_FWD0:   return int'(fwd_sel[3:0]);
      F_WB:     return int'(wb_expect);
      F_INFL:   return int'(inflight);
      default:  return int'(lat_err);
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d was not sampled (now %0d)", e.name, e.cyc, cyc);
      end else begin
        act = actual_of(e.fld);
        if (act != e.val) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, cyc, act, e.val);
        end
      end
    end
  end

  task automatic expect_v(input fld_e f, input int v, input string nm);
    exp_t e;
    e.cyc = cyc; e.fld = f; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wr_en = 1'b0; issue_rf = '0; issue_dst = '0;
    issue_lat = 4'd1; src_valid = '0; src_rf = '0; src_idx = '0;
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic do_issue(input rf_sel_t rf, input int dst, input int lat);
    issue_valid = 1'b1; issue_wr_en = 1'b1; issue_rf = rf;
    issue_dst = 5'(dst); issue_lat = 4'(lat);
  endtask

  task automatic src0(input rf_sel_t rf, input int idx);
    src_valid[0] = 1'b1; src_rf[0] = rf; src_idx[4:0] = 5'(idx);
  endtask

  // Decode holds a non-writing instruction that reads one source.
  task automatic reader(input rf_sel_t rf, input int idx);
    issue_valid = 1'b1; issue_wr_en = 1'b0; issue_lat = 4'd1;
    src0(rf, idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    expect_v(F_INFL, 0, "initial_inflight");
    expect_v(F_LATERR, 0, "initial_lat_err");

    // Random activity, then reset.
    for (int i = 0; i < 20; i++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_wr_en = 1'($urandom_range(0, 1));
      issue_rf    = 1'($urandom_range(0, 1));
      issue_dst   = 5'($urandom_range(0, 31));
      issue_lat   = 4'($urandom_range(0, 15));
      src_valid   = 4'($urandom);
      src_rf      = 4'($urandom);
      src_idx     = 20'($urandom);
      hold        = ($urandom_range(0, 3) == 0);
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    // Post-reset cycle also issues scalar r5 lat 2 while reading r5.
    src0(RF_SCALAR, 5);
    do_issue(RF_SCALAR, 5, 2);
    expect_v(F_STALL, 0, "rst_stall");
    expect_v(F_INFL, 0, "rst_inflight");
    expect_v(F_WB, 0, "rst_wb_expect");
    expect_v(F_LATERR, 0, "rst_lat_err");
    expect_v(F_FWD0, 0, "rst_fwd_sel");
    step();

    // Scalar r5, lat 2: forward 2, then 1 with writeback.
    idle(); reader(RF_SCALAR, 5);
    expect_v(F_RAW, 0, "r5_raw");
    expect_v(F_STALL, 0, "r5_stall");
    expect_v(F_FWD0, 2, "r5_fwd2");
    expect_v(F_INFL, 1, "r5_inflight");
    step();
    expect_v(F_FWD0, 1, "r5_fwd1");
    expect_v(F_WB, 1, "r5_wb");
    step();
    expect_v(F_FWD0, 0, "r5_fwd0_retired");
    expect_v(F_WB, 0, "r5_wb_retired");
    expect_v(F_INFL, 0, "r5_inflight_retired");

    // Vector v3, lat 9: RAW while cnt 9..3, then forward 2 and 1.
    do_issue(RF_VECTOR, 3, 9);
    expect_v(F_STALL, 0, "v3_issue_stall");
    step();
    idle(); reader(RF_VECTOR, 3);
    for (int i = 0; i < 7; i++) begin
      expect_v(F_RAW, 1, "v3_raw");
      expect_v(F_STALL, 1, "v3_stall");
      step();
    end
    expect_v(F_RAW, 0, "v3_raw_clear");
    expect_v(F_FWD0, 2, "v3_fwd2");
    step();
    expect_v(F_FWD0, 1, "v3_fwd1");
    expect_v(F_WB, 2, "v3_wb_vector");
    step();
    idle();
    expect_v(F_INFL, 0, "v3_inflight_retired");

    // WAW: r7 lat 9 then r7 lat 2 stalls until cnt(r7) <= 2.
    do_issue(RF_SCALAR, 7, 9);
    step();
    idle(); do_issue(RF_SCALAR, 7, 2);
    for (int i = 0; i < 7; i++) begin
      expect_v(F_WAW, 1, "r7_waw");
      expect_v(F_STALL, 1, "r7_stall");
      step();
    end
    expect_v(F_WAW, 0, "r7_waw_clear");
    expect_v(F_STRUCT, 0, "r7_struct_clear");
    expect_v(F_STALL, 0, "r7_accept");
    step();
    idle(); reader(RF_SCALAR, 7);
    expect_v(F_INFL, 1, "r7_single_busy");
    expect_v(F_FWD0, 2, "r7_fwd2");
    expect_v(F_WB, 1, "r7_old_slot_wb");
    step();
    expect_v(F_FWD0, 1, "r7_fwd1");
    expect_v(F_WB, 1, "r7_new_slot_wb");
    step();
    idle();
    expect_v(F_INFL, 0, "r7_inflight_retired");
    expect_v(F_WB, 0, "r7_wb_retired");

    // Structural: r1 lat 4 then r2 lat 3 collides.
    do_issue(RF_SCALAR, 1, 4);
    step();
    idle(); do_issue(RF_SCALAR, 2, 3);
    expect_v(F_STRUCT, 1, "struct_lat3");
    expect_v(F_STALL, 1, "struct_lat3_stall");
    expect_v(F_WAW, 0, "struct_lat3_waw");
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    expect_v(F_INFL, 0, "struct_drained");
    // Same situation with lat 2: no collision.
    do_issue(RF_SCALAR, 1, 4);
    step();
    idle(); do_issue(RF_SCALAR, 2, 2);
    expect_v(F_STRUCT, 0, "struct_lat2");
    expect_v(F_STALL, 0, "struct_lat2_stall");
    step();
    idle();
    expect_v(F_INFL, 2, "struct_lat2_inflight");
    expect_v(F_WB, 0, "struct_lat2_wb0");
    step();
    expect_v(F_WB, 1, "struct_r2_wb");
    step();
    expect_v(F_WB, 1, "struct_r1_wb");
    expect_v(F_INFL, 1, "struct_one_left");
    step();
    expect_v(F_INFL, 0, "struct_all_retired");

    // Hold freezes counts; issue during hold is not accepted.
    do_issue(RF_SCALAR, 10, 6);
    step();
    idle(); do_issue(RF_VECTOR, 4, 5);
    step();
    idle(); hold = 1'b1; do_issue(RF_SCALAR, 20, 3); src0(RF_SCALAR, 11);
    for (int i = 0; i < 5; i++) begin
      expect_v(F_STALL, 0, "hold_stall");
      expect_v(F_INFL, 2, "hold_inflight");
      expect_v(F_WB, 0, "hold_wb");
      step();
    end
    idle(); reader(RF_SCALAR, 10);
    for (int i = 0; i < 3; i++) begin
      expect_v(F_RAW, 1, "post_hold_raw");
      step();
    end
    expect_v(F_RAW, 0, "post_hold_raw_clear");
    expect_v(F_FWD0, 2, "post_hold_fwd2");
    expect_v(F_INFL, 2, "post_hold_inflight");
    step();
    // The writes above were at cnt 1 now; flush drops them.
    idle(); flush = 1'b1;
    expect_v(F_WB, 3, "pre_flush_wb");
    step();
    idle();
    expect_v(F_INFL, 0, "flush_inflight");
    expect_v(F_WB, 0, "flush_wb");

    // Latency 0 is treated as 1 and flagged.
    do_issue(RF_SCALAR, 8, 0);
    expect_v(F_LATERR, 0, "lat0_before");
    step();
    idle(); reader(RF_SCALAR, 8);
    expect_v(F_LATERR, 1, "lat0_err");
    expect_v(F_INFL, 1, "lat0_inflight");
    expect_v(F_WB, 1, "lat0_wb");
    expect_v(F_FWD0, 1, "lat0_fwd1");
    step();
    idle();
    expect_v(F_LATERR, 1, "lat_err_sticky");
    expect_v(F_INFL, 0, "lat0_retired");
    step();
    step();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
